// File: rtl/ysyx_22041207_pkg.sv
// Shared definitions for the EXU multi-cycle units (divider FSM encodings, widths, helpers).
package ysyx_22041207_pkg;

    localparam int XLEN        = 64;
    localparam int DIV_ITER_64 = 64;
    localparam int DIV_ITER_32 = 32;
    localparam int MD_OP_W     = 3;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2,
        DIV_WAIT = 2'd3
    } div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    // Word ops look only at bits [31:0], extended according to signedness.
    function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] v, input logic word,
                                               input logic sgn);
        if (!word) return v;
        return sgn ? sext32(v[31:0]) : {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

endpackage

// File: rtl/ysyx_22041207_div_if.sv
// EXU <-> divider handshake bundle; the EXU is the master.
interface ysyx_22041207_div_if;
    import ysyx_22041207_pkg::*;

    // Handshake: an op is taken on a clock edge where div_valid && (div_ready || flush).
    // div_valid while busy and not flushing is ignored; out_valid is a one-cycle pulse and
    // quotient/remainder hold their value until the next out_valid.
    logic            div_valid;
    logic            flush;
    logic            div_signed;
    logic            div_word;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_ready;
    logic            out_valid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output div_valid, flush, div_signed, div_word, dividend, divisor,
        input  div_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  div_valid, flush, div_signed, div_word, dividend, divisor,
        output div_ready, out_valid, quotient, remainder
    );

endinterface

// File: rtl/ysyx_22041207_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend bit, trial subtract.
module ysyx_22041207_div_step
    import ysyx_22041207_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    // Two guard bits: {rem,bit} can reach 2*divisor, so the borrow needs its own bit.
    logic [XLEN+1:0] trial;
    logic [XLEN+1:0] diff;

    always_comb begin
        trial = {1'b0, rem, quo[XLEN-1]};
        diff  = trial - {2'b00, divisor};
        if (diff[XLEN+1]) begin
            rem_next = trial[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ysyx_22041207_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
module ysyx_22041207_div
    import ysyx_22041207_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22041207_div_if.slave       bus,
    output div_state_e               dbg_state
);

    div_state_e      state;
    logic [6:0]      count;
    logic [6:0]      op_iter;
    logic [6:0]      in_iter;
    logic [XLEN-1:0] rem_r, quo_r, dsr_r, a_raw;
    logic            op_word, neg_q, neg_r, is_dz, is_ovf;

    logic            accept;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;
    logic            a_neg, b_neg, in_dz, in_ovf;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] q_mag, q_fix, r_fix, q_res, r_res;

    assign accept    = bus.div_valid && (bus.div_ready || bus.flush);
    assign dbg_state = state;

    always_comb begin
        a_ext   = ext_op(bus.dividend, bus.div_word, bus.div_signed);
        b_ext   = ext_op(bus.divisor, bus.div_word, bus.div_signed);
        a_neg   = bus.div_signed && a_ext[XLEN-1];
        b_neg   = bus.div_signed && b_ext[XLEN-1];
        mag_a   = a_neg ? -a_ext : a_ext;
        mag_b   = b_neg ? -b_ext : b_ext;
        in_dz   = (b_ext == '0);
        in_ovf  = bus.div_signed && (&b_ext) &&
                  (a_ext == (bus.div_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}}));
        in_iter = bus.div_word ? 7'(DIV_ITER_32) : 7'(DIV_ITER_64);
        op_iter = op_word ? 7'(DIV_ITER_32) : 7'(DIV_ITER_64);
    end

    ysyx_22041207_div_step u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dsr_r),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_comb begin
        q_mag = op_word ? {{(XLEN-32){1'b0}}, quo_r[31:0]} : quo_r;
        q_fix = neg_q ? -q_mag : q_mag;
        r_fix = neg_r ? -rem_r : rem_r;
        if (is_dz) begin
            q_res = '1;
            r_res = op_word ? sext32(a_raw[31:0]) : a_raw;
        end else if (is_ovf) begin
            q_res = op_word ? sext32(a_raw[31:0]) : a_raw;
            r_res = '0;
        end else begin
            q_res = op_word ? sext32(q_fix[31:0]) : q_fix;
            r_res = op_word ? sext32(r_fix[31:0]) : r_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= DIV_IDLE;
            count         <= '0;
            bus.div_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            rem_r         <= '0;
            quo_r         <= '0;
            dsr_r         <= '0;
            a_raw         <= '0;
            op_word       <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            is_dz         <= 1'b0;
            is_ovf        <= 1'b0;
        end else if (accept) begin
            state         <= DIV_CALC;
            bus.div_ready <= 1'b0;
            bus.out_valid <= 1'b0;
            // Word ops park the 32-bit dividend in the top half so 32 shifts consume it exactly.
            quo_r         <= bus.div_word ? {mag_a[31:0], 32'b0} : mag_a;
            rem_r         <= '0;
            dsr_r         <= mag_b;
            a_raw         <= bus.dividend;
            op_word       <= bus.div_word;
            neg_q         <= a_neg ^ b_neg;
            neg_r         <= a_neg;
            is_dz         <= in_dz;
            is_ovf        <= in_ovf;
            // Special cases skip the iterations: preloading the full count lets CALC fall
            // straight through to DONE on the next edge.
            count         <= (in_dz || in_ovf) ? in_iter : 7'd0;
        end else if (bus.flush) begin
            state         <= DIV_IDLE;
            bus.div_ready <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: ;
                DIV_CALC: begin
                    if (count == op_iter) begin
                        state <= DIV_DONE;
                    end else begin
                        rem_r <= step_rem;
                        quo_r <= step_quo;
                        count <= count + 7'd1;
                    end
                end
                DIV_DONE: begin
                    bus.out_valid <= 1'b1;
                    bus.quotient  <= q_res;
                    bus.remainder <= r_res;
                    state         <= DIV_WAIT;
                end
                DIV_WAIT: begin
                    bus.out_valid <= 1'b0;
                    bus.div_ready <= 1'b1;
                    state         <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_div.sv
// Directed bench for the iterative divider: results, latency, special cases, flush and reset.
module tb_ysyx_22041207_div;
    import ysyx_22041207_pkg::*;

    logic       clk;
    logic       rst;
    div_state_e dbg_state;
    int         checks   = 0;
    int         failures = 0;

    ysyx_22041207_div_if bus();

    ysyx_22041207_div dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives an op and returns just after its accept edge; div_valid stays high like the EXU.
    task automatic start_op(input logic sgn, input logic wd, input logic [63:0] a,
                            input logic [63:0] b);
        bus.div_signed = sgn;
        bus.div_word   = wd;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.div_valid  = 1'b1;
        @(posedge clk); #1;
    endtask

    // Counts edges after the accept edge until out_valid; 201 means it never came.
    task automatic wait_result(output int lat);
        bit seen;
        seen = 0;
        lat  = 201;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                seen = 1;
                lat  = i;
            end
        end
        bus.div_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.div_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.div_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.quotient !== 64'h0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", bus.quotient); end
        checks++; if (bus.remainder !== 64'h0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", bus.remainder); end
        checks++; if (dbg_state !== DIV_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, DIV_IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_divu();
        int lat;
        start_op(1'b0, 1'b0, 64'd100, 64'd7);
        checks++; if (bus.div_ready !== 1'b0) begin failures++; $display("FAIL divu_busy got=%b exp=0", bus.div_ready); end
        // Operands must be latched: changing them while busy has no effect.
        bus.dividend = 64'hDEAD;
        bus.divisor  = 64'd3;
        wait_result(lat);
        checks++; if (lat !== 66) begin failures++; $display("FAIL divu_latency got=%0d exp=66", lat); end
        checks++; if (bus.quotient !== 64'd14) begin failures++; $display("FAIL divu_quotient got=%h exp=%h", bus.quotient, 64'd14); end
        checks++; if (bus.remainder !== 64'd2) begin failures++; $display("FAIL divu_remainder got=%h exp=%h", bus.remainder, 64'd2); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL divu_pulse_width got=%b exp=0", bus.out_valid); end
        checks++; if (bus.div_ready !== 1'b1) begin failures++; $display("FAIL divu_ready_back got=%b exp=1", bus.div_ready); end
        checks++; if (bus.quotient !== 64'd14) begin failures++; $display("FAIL divu_quotient_held got=%h exp=%h", bus.quotient, 64'd14); end
    endtask

    task automatic test_signed();
        int lat;
        start_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        wait_result(lat);
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_neg_pos_q got=%h exp=%h", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFD); end
        checks++; if (bus.remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL div_neg_pos_r got=%h exp=%h", bus.remainder, 64'hFFFF_FFFF_FFFF_FFFF); end
        @(posedge clk); #1;
        start_op(1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_result(lat);
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_pos_neg_q got=%h exp=%h", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFD); end
        checks++; if (bus.remainder !== 64'd1) begin failures++; $display("FAIL div_pos_neg_r got=%h exp=%h", bus.remainder, 64'd1); end
        checks++; if (lat !== 66) begin failures++; $display("FAIL div_signed_latency got=%0d exp=66", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(1'b1, 1'b0, 64'h1234, 64'h0);
        wait_result(lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL divzero_latency got=%0d exp=2", lat); end
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divzero_q got=%h exp=%h", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFF); end
        checks++; if (bus.remainder !== 64'h1234) begin failures++; $display("FAIL divzero_r got=%h exp=%h", bus.remainder, 64'h1234); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int lat;
        start_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result(lat);
        checks++; if (bus.quotient !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL ovf64_q got=%h exp=%h", bus.quotient, 64'h8000_0000_0000_0000); end
        checks++; if (bus.remainder !== 64'h0) begin failures++; $display("FAIL ovf64_r got=%h exp=0", bus.remainder); end
        @(posedge clk); #1;
        start_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_result(lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL ovf32_latency got=%0d exp=2", lat); end
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL ovf32_q got=%h exp=%h", bus.quotient, 64'hFFFF_FFFF_8000_0000); end
        checks++; if (bus.remainder !== 64'h0) begin failures++; $display("FAIL ovf32_r got=%h exp=0", bus.remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        int lat;
        start_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_result(lat);
        checks++; if (lat !== 34) begin failures++; $display("FAIL divuw_latency got=%0d exp=34", lat); end
        checks++; if (bus.quotient !== 64'h0000_0000_7FFF_FFFF) begin failures++; $display("FAIL divuw_q got=%h exp=%h", bus.quotient, 64'h0000_0000_7FFF_FFFF); end
        checks++; if (bus.remainder !== 64'd1) begin failures++; $display("FAIL divuw_r got=%h exp=%h", bus.remainder, 64'd1); end
        @(posedge clk); #1;
        // Upper dividend bits are junk on purpose; only bits [31:0] (-7) may count.
        start_op(1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2);
        wait_result(lat);
        checks++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL divw_q got=%h exp=%h", bus.quotient, 64'hFFFF_FFFF_FFFF_FFFD); end
        checks++; if (bus.remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL divw_r got=%h exp=%h", bus.remainder, 64'hFFFF_FFFF_FFFF_FFFF); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_new();
        int lat;
        start_op(1'b0, 1'b0, 64'd1000, 64'd3);
        bus.div_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        start_op(1'b0, 1'b0, 64'd9, 64'd3);
        bus.flush = 1'b0;
        wait_result(lat);
        checks++; if (lat !== 66) begin failures++; $display("FAIL flush_new_latency got=%0d exp=66", lat); end
        checks++; if (bus.quotient !== 64'd3) begin failures++; $display("FAIL flush_new_q got=%h exp=%h", bus.quotient, 64'd3); end
        checks++; if (bus.remainder !== 64'd0) begin failures++; $display("FAIL flush_new_r got=%h exp=0", bus.remainder); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_only();
        int spurious;
        start_op(1'b0, 1'b0, 64'd500, 64'd7);
        bus.div_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        checks++; if (bus.div_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", bus.div_ready); end
        checks++; if (dbg_state !== DIV_IDLE) begin failures++; $display("FAIL flush_state got=%0d exp=%0d", dbg_state, DIV_IDLE); end
        checks++; if (bus.quotient !== 64'd3) begin failures++; $display("FAIL flush_q_kept got=%h exp=%h", bus.quotient, 64'd3); end
        spurious = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) spurious++;
        end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL flush_no_result got=%0d exp=0", spurious); end
    endtask

    task automatic test_rst_mid();
        start_op(1'b0, 1'b0, 64'd77, 64'd5);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.div_valid = 1'b0;
        checks++; if (bus.div_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", bus.div_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.quotient !== 64'h0) begin failures++; $display("FAIL rst_mid_quotient got=%h exp=0", bus.quotient); end
        checks++; if (dbg_state !== DIV_IDLE) begin failures++; $display("FAIL rst_mid_state got=%0d exp=%0d", dbg_state, DIV_IDLE); end
    endtask

    initial begin
        rst            = 1'b1;
        bus.div_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_word   = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        test_reset();
        test_divu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_word();
        test_flush_new();
        test_flush_only();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
